reg_scoreboard: RTL and testbench
=================================

// Module: reg_scoreboard
// PURPOSE
//  Tracks in-flight writes to the 8 architectural registers between decode issue and writeback.
//  Stalls decode when an enabled source register has a pending write, so the register file is never read stale.
//  Sits in decode beside the register file: consumes its read enables/addresses and the writeback write port.
// PARAMETERS
//  NUM_REGS     8   number of architectural registers
//  ADDR_W       3   register address width, clog2(NUM_REGS)
//  CNT_W        2   per-register in-flight write counter width (max 2**CNT_W-1 pending)
//  STALL_CNT_W  16  width of the stall-cycle performance counter
// PORTS
//  i_clk           in   1            clock, rising edge
//  i_reset         in   1            synchronous, active-high reset
//  i_read1         in   1            source 1 read enable (same signal as the register file's)
//  i_read_addr1    in   ADDR_W       source 1 register address
//  i_read2         in   1            source 2 read enable
//  i_read_addr2    in   ADDR_W       source 2 register address
//  i_issue         in   1            decode requests issue of an instruction
//  i_issue_write   in   1            the issuing instruction writes a register
//  i_issue_dst     in   ADDR_W       destination register of the issuing instruction
//  i_wb            in   1            writeback commits a register write this cycle
//  i_wb_addr       in   ADDR_W       writeback destination register
//  i_flush         in   1            pipeline drained or squashed; clear all pending state
//  o_stall         out  1            hold decode; issue is not accepted
//  o_fwd1          out  1            source 1 taken from the writeback bus this cycle
//  o_fwd2          out  1            source 2 taken from the writeback bus this cycle
//  o_error         out  1            sticky: writeback to a register with no pending write
//  o_stall_cycles  out  STALL_CNT_W  saturating count of cycles with o_stall=1
// BEHAVIOUR
//  - State: cnt[r] (CNT_W bits) per register, the o_error flop, and the stall counter. No other FSM.
//  - Reset: all cnt=0, o_error=0, o_stall_cycles=0. Combinational outputs then give o_stall=0, o_fwd1=o_fwd2=0.
//  - hazN = i_readN & (cnt[i_read_addrN] != 0), excluding any hazard removed by forwarding (see CONFIGURATION).
//  - sat  = i_issue & i_issue_write & (cnt[i_issue_dst] == max).
//  - o_stall = hazard1 | hazard2 | sat. Combinational from registered cnt and current inputs.
//  - Issue is accepted when i_issue & !o_stall.
//      Accepted with i_issue_write: cnt[dst] increments at the next edge.
//      The new count is visible one cycle after issue (1-cycle latency).
//  - Writeback with i_wb and cnt[wb_addr] > 0: cnt[wb_addr] decrements at the next edge.
//  - Simultaneous accepted issue and writeback to the same register: cnt unchanged.
//  - Writeback to a register with cnt==0: cnt stays 0 (no wrap) and o_error is set next cycle.
//      o_error is cleared only by i_reset.
//  - The register file writes on the clock edge, so a same-cycle writeback does not clear a hazard.
//      Without forwarding, stall persists until cnt reaches 0.
//  - i_flush has priority over issue and writeback: all cnt=0 at the next edge and the issue is dropped.
//      o_error and o_stall_cycles are kept.
//  - o_stall_cycles increments each cycle o_stall=1 and saturates at all-ones.
//  - A reset asserted mid-operation overrides everything: state returns to reset values at that edge.
//  - Register 0 is an ordinary register (no hardwired zero).
// CONFIGURATION
//  SB_WB_FORWARD_EN defined:
//    - A source whose address equals i_wb_addr while i_wb=1 and cnt==1 is not a hazard.
//    - The matching o_fwdN=1; the datapath muxes the writeback data onto that source.
//  SB_WB_FORWARD_EN undefined:
//    - o_fwd1 and o_fwd2 are tied to 0.
//    - Such a source stalls one more cycle and reads the register file after the write edge.
// TESTING
//  1 reset; issue write R3; next cycle read1 R3 -> o_stall=1; wb R3 -> o_stall=0 the cycle after (no fwd).
//  2 With SB_WB_FORWARD_EN: issue R5, then read2 R5 concurrent with wb R5 -> o_stall=0, o_fwd2=1.
//    Without the macro -> o_stall=1, o_fwd2=0.
//  3 Issue R2 three times with no wb -> cnt=3; 4th issue to R2 -> o_stall=1 and cnt stays 3;
//    three wb R2 -> cnt=0.
//  4 Same cycle: issue write R1 and wb R1 with cnt[R1]=1 -> cnt[R1] stays 1; read R1 next cycle stalls.
//  5 wb R7 with cnt[R7]=0 -> o_error=1 next cycle and stays 1 across i_flush; only i_reset clears it.
//  6 Pending writes on R0/R4 plus i_flush, with a concurrent issue to R6 -> all cnt=0 and R6 not recorded;
//    o_stall_cycles holds its value.

Source files
------------

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Decode-stage register scoreboard. Tracks how many issued writes to each of
//   the NUM_REGS architectural registers are still waiting for writeback, and
//   holds decode while an enabled source register still has a write pending.
//   Optional feature macro: SB_WB_FORWARD_EN. When it is defined, a source that
//   is written back in the current cycle as its last pending write is taken from
//   the writeback bus. When it is undefined, that source stalls one more cycle.
//
// Ports
//   i_clk, i_reset              clock (rising edge), synchronous active-high reset
//   i_read1/2, i_read_addr1/2   source read enables and addresses (shared with regfile)
//   i_issue, i_issue_write,
//   i_issue_dst                 issue request, writes-a-register flag, destination
//   i_wb, i_wb_addr             writeback commit and its destination
//   i_flush                     clear all pending writes (error/stall counter kept)
//   o_stall                     hold decode, issue not accepted (combinational)
//   o_fwd1/2                    source taken from the writeback bus this cycle
//   o_error                     sticky: writeback to a register with nothing pending
//   o_stall_cycles              saturating count of stalled cycles
module reg_scoreboard #(
  parameter int NUM_REGS    = 8,
  parameter int ADDR_W      = 3,
  parameter int CNT_W       = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_read1,
  input  logic [ADDR_W-1:0]      i_read_addr1,
  input  logic                   i_read2,
  input  logic [ADDR_W-1:0]      i_read_addr2,
  input  logic                   i_issue,
  input  logic                   i_issue_write,
  input  logic [ADDR_W-1:0]      i_issue_dst,
  input  logic                   i_wb,
  input  logic [ADDR_W-1:0]      i_wb_addr,
  input  logic                   i_flush,
  output logic                   o_stall,
  output logic                   o_fwd1,
  output logic                   o_fwd2,
  output logic                   o_error,
  output logic [STALL_CNT_W-1:0] o_stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]       cnt_q [NUM_REGS];
  logic [CNT_W-1:0]       cnt_d [NUM_REGS];
  logic                   error_q, error_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic pend1_s, pend2_s, fwd1_s, fwd2_s, haz1_s, haz2_s, sat_s, stall_s;
  logic accept_wr_s, wb_live_s, wb_orphan_s;

  // Hazard, saturation and forwarding decode from registered counts.
  always_comb begin
    pend1_s = i_read1 && (cnt_q[i_read_addr1] != {CNT_W{1'b0}});
    pend2_s = i_read2 && (cnt_q[i_read_addr2] != {CNT_W{1'b0}});
`ifdef SB_WB_FORWARD_EN
    // Only the last pending write can be bypassed: with more in flight, the
    // value on the writeback bus is not the one this source must see.
    fwd1_s = pend1_s && i_wb && (i_wb_addr == i_read_addr1) && (cnt_q[i_read_addr1] == CNT_ONE);
    fwd2_s = pend2_s && i_wb && (i_wb_addr == i_read_addr2) && (cnt_q[i_read_addr2] == CNT_ONE);
`else
    fwd1_s = 1'b0;
    fwd2_s = 1'b0;
`endif
    haz1_s  = pend1_s && !fwd1_s;
    haz2_s  = pend2_s && !fwd2_s;
    sat_s   = i_issue && i_issue_write && (cnt_q[i_issue_dst] == CNT_MAX);
    stall_s = haz1_s || haz2_s || sat_s;
  end

  // Next-state for pending counters, sticky error and stall counter.
  always_comb begin
    accept_wr_s = i_issue && i_issue_write && !stall_s;
    wb_live_s   = i_wb && (cnt_q[i_wb_addr] != {CNT_W{1'b0}});
    wb_orphan_s = i_wb && (cnt_q[i_wb_addr] == {CNT_W{1'b0}});
    error_d     = error_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    if (i_flush) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_d[r] = {CNT_W{1'b0}};
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        // Increment and decrement on the same register cancel out.
        if (accept_wr_s && (i_issue_dst == ADDR_W'(r)) &&
            !(wb_live_s && (i_wb_addr == ADDR_W'(r)))) begin
          cnt_d[r] = cnt_q[r] + CNT_ONE;
        end else if (wb_live_s && (i_wb_addr == ADDR_W'(r)) &&
                     !(accept_wr_s && (i_issue_dst == ADDR_W'(r)))) begin
          cnt_d[r] = cnt_q[r] - CNT_ONE;
        end else begin
          cnt_d[r] = cnt_q[r];
        end
      end
      if (wb_orphan_s) begin
        error_d = 1'b1;
      end else begin
        error_d = error_q;
      end
    end
    if (stall_s && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= {CNT_W{1'b0}};
      end
      error_q     <= 1'b0;
      stall_cnt_q <= {STALL_CNT_W{1'b0}};
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      error_q     <= error_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall        = stall_s;
  assign o_fwd1         = fwd1_s;
  assign o_fwd2         = fwd2_s;
  assign o_error        = error_q;
  assign o_stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd1 = 1'b0, rd2 = 1'b0, iss = 1'b0, iw = 1'b0, wb = 1'b0, fl = 1'b0;
  logic [2:0]  a1 = 3'd0, a2 = 3'd0, dst = 3'd0, wa = 3'd0;
  logic        stall, fwd1, fwd2, err;
  logic [15:0] sc;

`ifdef SB_WB_FORWARD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic        stall;
    logic        fwd1;
    logic        fwd2;
    logic        err;
    logic [15:0] sc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic        exp_err  = 1'b0;
  logic [15:0] exp_sc   = 16'd0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .i_clk(clk), .i_reset(rst),
    .i_read1(rd1), .i_read_addr1(a1), .i_read2(rd2), .i_read_addr2(a2),
    .i_issue(iss), .i_issue_write(iw), .i_issue_dst(dst),
    .i_wb(wb), .i_wb_addr(wa), .i_flush(fl),
    .o_stall(stall), .o_fwd1(fwd1), .o_fwd2(fwd2), .o_error(err),
    .o_stall_cycles(sc)
  );

  // Pop one expectation and compare it with the settled DUT outputs.
  task automatic check_out();
    exp_t e;
    e = sb_q.pop_front();
    n_assert++;
    assert (stall === e.stall) else begin
      n_fail++; $error("FAIL %s stall observed=%0b expected=%0b", e.tag, stall, e.stall);
    end
    n_assert++;
    assert (fwd1 === e.fwd1) else begin
      n_fail++; $error("FAIL %s fwd1 observed=%0b expected=%0b", e.tag, fwd1, e.fwd1);
    end
    n_assert++;
    assert (fwd2 === e.fwd2) else begin
      n_fail++; $error("FAIL %s fwd2 observed=%0b expected=%0b", e.tag, fwd2, e.fwd2);
    end
    n_assert++;
    assert (err === e.err) else begin
      n_fail++; $error("FAIL %s error observed=%0b expected=%0b", e.tag, err, e.err);
    end
    n_assert++;
    assert (sc === e.sc) else begin
      n_fail++; $error("FAIL %s stall_cycles observed=%0d expected=%0d", e.tag, sc, e.sc);
    end
  endtask

  // One clock cycle: drive inputs, push expectations, check, then advance the
  // stall-cycle expectation for the coming edge.
  task automatic cyc(input string tag,
                     input logic r1, input logic [2:0] ra1,
                     input logic r2, input logic [2:0] ra2,
                     input logic i_s, input logic i_w, input logic [2:0] d,
                     input logic w, input logic [2:0] w_a, input logic f,
                     input logic e_stall, input logic e_f1, input logic e_f2);
    exp_t e;
    @(negedge clk);
    rd1 = r1; a1 = ra1; rd2 = r2; a2 = ra2;
    iss = i_s; iw = i_w; dst = d; wb = w; wa = w_a; fl = f;
    e.tag = tag; e.stall = e_stall; e.fwd1 = e_f1; e.fwd2 = e_f2;
    e.err = exp_err; e.sc = exp_sc;
    sb_q.push_back(e);
    #1;
    check_out();
    if (e_stall) exp_sc = exp_sc + 16'd1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    cyc("reset_idle", 0,0, 0,0, 0,0,0, 0,0, 0, 0,0,0);

    // 1: issue R3, read1 R3 stalls, writeback clears it
    cyc("t1_issue_r3", 0,0, 0,0, 1,1,3, 0,0, 0, 0,0,0);
    cyc("t1_read_r3",  1,3, 0,0, 0,0,0, 0,0, 0, 1,0,0);
    cyc("t1_read_wb",  1,3, 0,0, 0,0,0, 1,3, 0, !FWD,FWD,0);
    cyc("t1_after_wb", 1,3, 0,0, 0,0,0, 0,0, 0, 0,0,0);

    // 2: issue R5, read2 R5 concurrent with wb R5
    cyc("t2_issue_r5", 0,0, 0,0, 1,1,5, 0,0, 0, 0,0,0);
    cyc("t2_read_wb",  0,0, 1,5, 0,0,0, 1,5, 0, !FWD,0,FWD);
    cyc("t2_after_wb", 0,0, 1,5, 0,0,0, 0,0, 0, 0,0,0);

    // 3: saturate R2 at 3 pending writes
    cyc("t3_iss1",     0,0, 0,0, 1,1,2, 0,0, 0, 0,0,0);
    cyc("t3_iss2",     0,0, 0,0, 1,1,2, 0,0, 0, 0,0,0);
    cyc("t3_iss3",     0,0, 0,0, 1,1,2, 0,0, 0, 0,0,0);
    cyc("t3_iss4_sat", 0,0, 0,0, 1,1,2, 0,0, 0, 1,0,0);
    cyc("t3_read_r2",  1,2, 0,0, 0,0,0, 0,0, 0, 1,0,0);
    cyc("t3_wb1",      0,0, 0,0, 0,0,0, 1,2, 0, 0,0,0);
    cyc("t3_wb2",      0,0, 0,0, 0,0,0, 1,2, 0, 0,0,0);
    cyc("t3_read_wb3", 1,2, 0,0, 0,0,0, 1,2, 0, !FWD,FWD,0);
    cyc("t3_empty",    1,2, 0,0, 0,0,0, 0,0, 0, 0,0,0);

    // 4: issue and writeback to R1 in the same cycle keep cnt at 1
    cyc("t4_issue_r1", 0,0, 0,0, 1,1,1, 0,0, 0, 0,0,0);
    cyc("t4_iss_wb",   0,0, 0,0, 1,1,1, 1,1, 0, 0,0,0);
    cyc("t4_read_r1",  1,1, 0,0, 0,0,0, 0,0, 0, 1,0,0);
    cyc("t4_drain",    0,0, 0,0, 0,0,0, 1,1, 0, 0,0,0);
    cyc("t4_empty",    0,0, 1,1, 0,0,0, 0,0, 0, 0,0,0);

    // 5: orphan writeback to R7 sets the sticky error
    cyc("t5_wb_r7",    0,0, 0,0, 0,0,0, 1,7, 0, 0,0,0);
    exp_err = 1'b1;
    cyc("t5_err_set",  0,0, 0,0, 0,0,0, 0,0, 0, 0,0,0);
    cyc("t5_flush",    0,0, 0,0, 0,0,0, 0,0, 1, 0,0,0);
    cyc("t5_err_kept", 0,0, 0,0, 0,0,0, 0,0, 0, 0,0,0);

    // 6: flush clears R0/R4 and drops a concurrent issue to R6
    cyc("t6_issue_r0", 0,0, 0,0, 1,1,0, 0,0, 0, 0,0,0);
    cyc("t6_issue_r4", 0,0, 0,0, 1,1,4, 0,0, 0, 0,0,0);
    cyc("t6_read_pend",1,0, 1,4, 0,0,0, 0,0, 0, 1,0,0);
    cyc("t6_flush_iss",0,0, 0,0, 1,1,6, 0,0, 1, 0,0,0);
    cyc("t6_read_clr", 1,0, 1,4, 0,0,0, 0,0, 0, 0,0,0);
    cyc("t6_read_r6",  1,6, 0,0, 0,0,0, 0,0, 0, 0,0,0);

    // Reset mid-operation clears error, stall counter and pending state
    cyc("rst_issue_r3", 0,0, 0,0, 1,1,3, 0,0, 0, 0,0,0);
    cyc("rst_read_r3",  1,3, 0,0, 0,0,0, 0,0, 0, 1,0,0);
    @(negedge clk);
    rd1 = 1'b0; iss = 1'b0; iw = 1'b0; wb = 1'b0; fl = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0;
    exp_sc  = 16'd0;
    cyc("rst_after",    1,3, 0,0, 0,0,0, 0,0, 0, 0,0,0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
